// File: rtl/alu_pkg.sv
// Shared opcode encodings and default widths for the alu datapath.
package alu_pkg;

  localparam int N_BITS_DATA_DEF = 8;
  localparam int N_BITS_OP_DEF   = 6;

  // MIPS R-type function codes
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU result, carry/borrow and signed-overflow logic.
module alu_core
  import alu_pkg::*;
#(
  parameter int N_BITS_DATA = N_BITS_DATA_DEF,
  parameter int N_BITS_OP   = N_BITS_OP_DEF
) (
  input  logic [N_BITS_DATA-1:0] dato_a,
  input  logic [N_BITS_DATA-1:0] dato_b,
  input  logic [N_BITS_OP-1:0]   operacion,
  output logic [N_BITS_DATA-1:0] resultado,
  output logic                   carry,
  output logic                   overflow,
  output logic                   valid_op
);

  localparam int MSB = N_BITS_DATA - 1;

  logic [N_BITS_DATA:0] sum;
  logic [N_BITS_DATA:0] diff;

  // One extra bit: sum[N] is the carry-out, diff[N] is set exactly when a < b unsigned.
  assign sum  = {1'b0, dato_a} + {1'b0, dato_b};
  assign diff = {1'b0, dato_a} - {1'b0, dato_b};

  always_comb begin
    resultado = '0;
    carry     = 1'b0;
    overflow  = 1'b0;
    valid_op  = 1'b1;
    case (operacion)
      ADD: begin
        resultado = sum[MSB:0];
        carry     = sum[N_BITS_DATA];
        overflow  = (dato_a[MSB] == dato_b[MSB]) && (sum[MSB] != dato_a[MSB]);
      end
      SUB: begin
        resultado = diff[MSB:0];
        carry     = diff[N_BITS_DATA];
        overflow  = (dato_a[MSB] != dato_b[MSB]) && (diff[MSB] != dato_a[MSB]);
      end
      AND: resultado = dato_a & dato_b;
      OR:  resultado = dato_a | dato_b;
      XOR: resultado = dato_a ^ dato_b;
      NOR: resultado = ~(dato_a | dato_b);
      // Shifts by >= width saturate naturally: >>> fills with the sign, >> with zeros.
      SRA: resultado = $unsigned($signed(dato_a) >>> dato_b);
      SRL: resultado = dato_a >> dato_b;
      default: valid_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// ALU top: combinational result path plus registered condition flags with async reset.
module alu
  import alu_pkg::*;
#(
  parameter int N_BITS_DATA = N_BITS_DATA_DEF,
  parameter int N_BITS_OP   = N_BITS_OP_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_BITS_DATA-1:0] i_dato_A,
  input  logic [N_BITS_DATA-1:0] i_dato_B,
  input  logic [N_BITS_OP-1:0]   i_operacion,
  output logic [N_BITS_DATA-1:0] o_resultado,
  output logic                   o_zero,
  output logic                   o_negative,
  output logic                   o_carry,
  output logic                   o_overflow,
  output logic                   o_invalid
);

  logic core_carry;
  logic core_overflow;
  logic core_valid;

  alu_core #(
    .N_BITS_DATA(N_BITS_DATA),
    .N_BITS_OP  (N_BITS_OP)
  ) u_core (
    .dato_a   (i_dato_A),
    .dato_b   (i_dato_B),
    .operacion(i_operacion),
    .resultado(o_resultado),
    .carry    (core_carry),
    .overflow (core_overflow),
    .valid_op (core_valid)
  );

  // Result never passes through reset; only the status flags are cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_zero     <= 1'b0;
      o_negative <= 1'b0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_invalid  <= 1'b0;
    end else begin
      o_zero     <= (o_resultado == '0);
      o_negative <= o_resultado[N_BITS_DATA-1];
      o_carry    <= core_carry;
      o_overflow <= core_overflow;
      o_invalid  <= !core_valid;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequence, randomized model regression.
module tb_alu;

  localparam int W = 8;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  // flags packed as {zero, negative, carry, overflow, invalid}
  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   flags;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] dato_a;
  logic [W-1:0] dato_b;
  logic [5:0]   operacion;
  logic [W-1:0] resultado;
  logic         zero, negative, carry, overflow, invalid;

  logic [4:0] exp_q[$];
  int n_vec;
  int n_err;

  alu #(.N_BITS_DATA(W), .N_BITS_OP(6)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_dato_A   (dato_a),
    .i_dato_B   (dato_b),
    .i_operacion(operacion),
    .o_resultado(resultado),
    .o_zero     (zero),
    .o_negative (negative),
    .o_carry    (carry),
    .o_overflow (overflow),
    .o_invalid  (invalid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] dut_flags();
    return {zero, negative, carry, overflow, invalid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic; returns {result, flags}.
  function automatic logic [W+4:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int ua, ub, sa, sb, r, p, q;
    bit c, v, inv;
    logic [W-1:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = 0; c = 0; v = 0; inv = 0;
    case (op)
      OP_ADD: begin r = ua + ub; c = (r >= 256); v = (sa + sb > 127) || (sa + sb < -128); end
      OP_SUB: begin r = ua - ub; c = (ua < ub);  v = (sa - sb > 127) || (sa - sb < -128); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOR: r = ~(ua | ub);
      OP_SRA: begin
        if (ub >= W) r = (sa < 0) ? 255 : 0;
        else begin
          p = 1 << ub;
          q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
          r = q;
        end
      end
      OP_SRL: r = (ub >= W) ? 0 : ua / (1 << ub);
      default: begin r = 0; inv = 1; end
    endcase
    r = r & 255;
    res = r[W-1:0];
    return {res, (r == 0), (r >= 128), c, v, inv};
  endfunction

  // driver: change inputs on the falling edge, check result 1 ns later, flags after the next rise
  task automatic apply_vec(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_res, input logic [4:0] exp_flags,
                           input string name);
    @(negedge clk);
    operacion = o;
    dato_a    = x;
    dato_b    = y;
    #1;
    check({name, " result"}, 32'(resultado), 32'(exp_res));
    exp_q.push_back(exp_flags);
    @(posedge clk);
    #1;
    check({name, " flags"}, 32'(dut_flags()), 32'(exp_q.pop_front()));
  endtask

  vec_t vecs[14];
  logic [5:0] ops[8];
  logic [W+4:0] m;

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 5'b01010};
    vecs[1]  = '{OP_SUB,  8'h05, 8'h07, 8'hFE, 5'b01100};
    vecs[2]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 5'b00010};
    vecs[3]  = '{OP_AND,  8'hC3, 8'h5A, 8'h42, 5'b00000};
    vecs[4]  = '{OP_OR,   8'hC3, 8'h5A, 8'hDB, 5'b01000};
    vecs[5]  = '{OP_XOR,  8'hC3, 8'h5A, 8'h99, 5'b01000};
    vecs[6]  = '{OP_NOR,  8'hC3, 8'h5A, 8'h24, 5'b00000};
    vecs[7]  = '{OP_SRA,  8'h90, 8'h02, 8'hE4, 5'b01000};
    vecs[8]  = '{OP_SRL,  8'h90, 8'h02, 8'h24, 5'b00000};
    vecs[9]  = '{OP_SRA,  8'h90, 8'h83, 8'hFF, 5'b01000};
    vecs[10] = '{OP_SRL,  8'h90, 8'h83, 8'h00, 5'b10000};
    vecs[11] = '{6'h3F,   8'h12, 8'h34, 8'h00, 5'b10001};
    vecs[12] = '{OP_ADD,  8'h80, 8'h80, 8'h00, 5'b10110};
    vecs[13] = '{OP_SUB,  8'h33, 8'h33, 8'h00, 5'b10000};

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

    // reset state: flags held at 0, result still live
    rst_n     = 1'b0;
    operacion = OP_ADD;
    dato_a    = 8'h7F;
    dato_b    = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", 32'(dut_flags()), 32'h0);
    check("reset result", 32'(resultado), 32'h80);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first edge after reset flags", 32'(dut_flags()), 32'(5'b01010));

    for (int i = 0; i < 14; i++)
      apply_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags,
                $sformatf("vec%0d", i));

    // async reset mid-cycle: flags drop at once, result untouched
    apply_vec(OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b01010, "pre-reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset flags", 32'(dut_flags()), 32'h0);
    check("async reset result", 32'(resultado), 32'h80);
    @(posedge clk);
    #1;
    check("held reset flags", 32'(dut_flags()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-release flags", 32'(dut_flags()), 32'(5'b01010));

    // randomized regression against the model
    for (int g = 0; g < 40; g++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = (g % 2 == 0) ? W'($urandom_range(0, 9)) : W'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++) begin
        m = model(ops[k], ra, rb);
        apply_vec(ops[k], ra, rb, m[W+4:5], m[4:0], $sformatf("rand g%0d op%0d", g, k));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
Parameterised integer ALU for the Basys3 datapath.
- The result path is purely combinational: operands A and B plus a 6-bit MIPS-style function code give o_resultado in the same cycle.
- A clocked status stage registers condition flags (zero, negative, carry/borrow, overflow, invalid-op) for downstream control and LED display.

Parameters:
- N_BITS_DATA, 8: operand and result width in bits; must be ≥ 2.
- N_BITS_OP, 6: opcode width in bits.

Ports:
- i_clk, in, 1: system clock; flags update on its rising edge.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_dato_A, in, N_BITS_DATA: operand A, two's-complement signed.
- i_dato_B, in, N_BITS_DATA: operand B, signed; treated as an unsigned shift amount for shift ops.
- i_operacion, in, N_BITS_OP: opcode.
- o_resultado, out, N_BITS_DATA: combinational result.
- o_zero, out, 1: registered; result was all zeros.
- o_negative, out, 1: registered; result MSB.
- o_carry, out, 1: registered; ADD carry-out or SUB borrow.
- o_overflow, out, 1: registered; signed overflow on ADD or SUB.
- o_invalid, out, 1: registered; opcode was not recognised.

Behaviour:
- Opcodes and results. All results are truncated to N_BITS_DATA (modulo 2^N).
  - ADD 6'b100000: A+B
  - SUB 6'b100010: A-B
  - AND 6'b100100: A&B
  - OR 6'b100101: A|B
  - XOR 6'b100110: A^B
  - NOR 6'b100111: ~(A|B)
  - SRA 6'b000011: A arithmetic-right-shifted by unsigned(B); sign fill. A shift of ≥ N_BITS_DATA gives all copies of A's MSB.
  - SRL 6'b000010: A logical-right-shifted by unsigned(B); zero fill. A shift of ≥ N_BITS_DATA gives 0.
  - Any other opcode: o_resultado = 0.
- o_resultado is combinational with zero latency and is never affected by reset.
  - It must settle within a fraction of a cycle after any input change.
  - No latch inference: every case assigns the result.
- Carry:
  - ADD: bit N of the zero-extended unsigned sum.
  - SUB: 1 when unsigned(A) < unsigned(B), i.e. a borrow.
  - All other ops: 0.
- Overflow:
  - ADD: set when A and B have the same sign and the result sign differs.
  - SUB: set when A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- Flag registers:
  - On each rising i_clk, all five flags capture the values derived from the current combinational result and opcode.
  - Latency is one cycle.
- Reset:
  - i_rst_n low clears all flags to 0 immediately, without waiting for a clock edge.
  - Flags stay 0 while reset is asserted.
  - On the first rising edge after release, flags reflect current inputs.
  - Reset asserted mid-operation does not disturb o_resultado.
- There is no handshake and no state machine; the inputs may change every cycle.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams ADD, SUB, AND, OR, XOR, SRA, SRL, NOR;
  - default widths of 8 and 6.
- One natural sub-module, alu_core: the purely combinational result, carry and overflow logic.
- The top alu adds the flag registers, the zero/negative/invalid decode and the async reset.

Test Plan:
- ADD A=0x7F B=0x01 -> o_resultado=0x80 immediately. After the next edge: overflow=1, negative=1, carry=0, zero=0.
- SUB A=0x05 B=0x07 -> o_resultado=0xFE; carry=1, negative=1, overflow=0. SUB A=0x80 B=0x01 -> 0x7F, overflow=1.
- A=0xC3 B=0x5A:
  - AND -> 0x42
  - OR -> 0xDB
  - XOR -> 0x99
  - NOR -> 0x24
  - In each case the result is valid 1 ns after the opcode changes.
- A=0x90 B=0x02: SRA -> 0xE4, SRL -> 0x24. A=0x90 B=0x83: SRA -> 0xFF, SRL -> 0x00.
- Opcode 6'b111111 -> o_resultado=0x00; o_invalid=1 after the edge. ADD A=0x80 B=0x80 -> 0x00; zero=1, carry=1, overflow=1.
- Randomised regression: each group randomises A and B, then steps through all 8 opcodes one per cycle and compares against the golden formulas above. Assert i_rst_n low between edges -> all flags drop to 0 immediately while o_resultado is unchanged.
